// File: rtl/uart_act_pkg.sv
// uart_act_pkg: shared types and sizing for the UART/activation channel.
// Contents: state enum, byte-index width helper, counter widths, checksum byte count.
// Optional: UART_ACT_CHANNEL_CHECKSUM_EN adds one XOR checksum byte per frame.
package uart_act_pkg;
    typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND} state_t;
    localparam int GAP_W  = 16;
    localparam int WAIT_W = 8;
`ifdef UART_ACT_CHANNEL_CHECKSUM_EN
    localparam int CK_BYTES = 1;
`else
    localparam int CK_BYTES = 0;
`endif
    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/uart_act_channel_if.sv
// uart_act_channel_if: UART rx/tx, core handshake and status bundle.
// Modports: slave = channel side, master = surrounding UART/core/monitor side.
// Optional: UART_ACT_CHANNEL_CHECKSUM_EN adds err_cksum.
interface uart_act_channel_if #(
    parameter int DATA_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] op_data;
    logic              op_start;
    logic [DATA_W-1:0] res_data;
    logic              res_done;
    logic              tx_line_en;
    logic              busy;
    logic              err_timeout;
    logic              err_overrun;
`ifdef UART_ACT_CHANNEL_CHECKSUM_EN
    logic              err_cksum;
`endif
    modport slave (
        input  rx_data, rx_valid, tx_ready, res_data, res_done,
`ifdef UART_ACT_CHANNEL_CHECKSUM_EN
        output err_cksum,
`endif
        output tx_data, tx_valid, op_data, op_start, tx_line_en, busy, err_timeout, err_overrun
    );
    modport master (
        output rx_data, rx_valid, tx_ready, res_data, res_done,
`ifdef UART_ACT_CHANNEL_CHECKSUM_EN
        input  err_cksum,
`endif
        input  tx_data, tx_valid, op_data, op_start, tx_line_en, busy, err_timeout, err_overrun
    );
endinterface

// File: rtl/act_frame_ser.sv
// act_frame_ser: result register and little-endian byte serialiser with valid/ready hold.
// Ports: clk, reset (async, active-low), load (capture res_data and start sending),
// res_data, tx_ready in; tx_data, tx_valid, sent (last byte accepted this cycle) out.
// Optional: UART_ACT_CHANNEL_CHECKSUM_EN appends the XOR of the result bytes.
module act_frame_ser
    import uart_act_pkg::*;
#(
    parameter int N_BYTES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [8*N_BYTES-1:0] res_data,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 sent
);
    localparam int IW   = idx_w(N_BYTES);
    localparam int LAST = N_BYTES + CK_BYTES - 1;

    logic [8*N_BYTES-1:0] res_q;
    logic [IW-1:0]        idx;
    logic                 last;

    assign last = idx == IW'(LAST);
    assign sent = tx_valid && tx_ready && last;

`ifdef UART_ACT_CHANNEL_CHECKSUM_EN
    logic [7:0] ck;
    always_comb begin
        ck = '0;
        for (int i = 0; i < N_BYTES; i++) ck ^= res_q[8*i +: 8];
    end
    assign tx_data = (idx == IW'(N_BYTES)) ? ck : 8'(res_q >> {idx, 3'b000});
`else
    assign tx_data = 8'(res_q >> {idx, 3'b000});
`endif

    // idx only moves on an accepted byte, so tx_data is stable while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            res_q    <= res_data;
            idx      <= '0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            idx      <= idx + 1'b1;
            tx_valid <= !last;
        end
    end
endmodule

// File: rtl/uart_act_channel.sv
// uart_act_channel: assembles UART bytes into an operand, runs the activation core, returns the result.
// Ports: clk, reset (async, active-low), bus (uart_act_channel_if.slave: UART rx/tx bytes,
// op_data/op_start and res_data/res_done core handshake, busy, tx_line_en, error pulses).
// Optional: UART_ACT_CHANNEL_CHECKSUM_EN checks/appends an XOR checksum byte and adds err_cksum.
module uart_act_channel
    import uart_act_pkg::*;
#(
    parameter int N_BYTES   = 2,
    parameter int USE_DONE  = 1,
    parameter int FIXED_LAT = 16,
    parameter int TIMEOUT   = 255,
    parameter int RX_GAP    = 1023
) (
    input logic               clk,
    input logic               reset,
    uart_act_channel_if.slave bus
);
    localparam int DATA_W  = 8 * N_BYTES;
    localparam int IW      = idx_w(N_BYTES);
    localparam int RX_LAST = N_BYTES + CK_BYTES - 1;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [GAP_W-1:0]  gap;
    logic [WAIT_W-1:0] wcnt;
    logic [DATA_W-1:0] asm_q, asm_next, frame, op_data;
    logic              op_start, err_timeout, wait_done, capture, tx_valid, sent, ck_ok, rx_last;

    // Bytes shift in from the top so the first byte ends up in [7:0].
    assign asm_next  = (asm_q >> 8) | (DATA_W'(bus.rx_data) << (DATA_W - 8));
    assign rx_last   = bus.rx_valid && state == RECV && idx == IW'(RX_LAST);
    assign wait_done = (USE_DONE != 0) ? bus.res_done : wcnt == WAIT_W'(FIXED_LAT - 1);
    assign capture   = state == WAIT && wait_done;

`ifdef UART_ACT_CHANNEL_CHECKSUM_EN
    logic [7:0] ck_q;
    logic       err_cksum;
    assign ck_ok = bus.rx_data == ck_q;
    assign frame = asm_q;
    assign bus.err_cksum = err_cksum;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ck_q      <= '0;
            err_cksum <= 1'b0;
        end else begin
            ck_q      <= !bus.rx_valid ? ck_q : (state == IDLE) ? bus.rx_data : ck_q ^ bus.rx_data;
            err_cksum <= rx_last && !ck_ok;
        end
    end
`else
    assign ck_ok = 1'b1;
    assign frame = asm_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            gap         <= '0;
            wcnt        <= '0;
            asm_q       <= '0;
            op_data     <= '0;
            op_start    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            op_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: if (bus.rx_valid) begin
                    asm_q <= asm_next;
                    idx   <= IW'(1);
                    gap   <= '0;
                    if (RX_LAST == 0) begin
                        op_data  <= asm_next;
                        op_start <= 1'b1;
                        state    <= START;
                    end else begin
                        state <= RECV;
                    end
                end
                RECV: if (bus.rx_valid) begin
                    gap <= '0;
                    idx <= idx + 1'b1;
                    if (idx < IW'(N_BYTES)) asm_q <= asm_next;
                    if (rx_last) begin
                        if (ck_ok) begin
                            op_data  <= frame;
                            op_start <= 1'b1;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end else if (gap == GAP_W'(RX_GAP - 1)) begin
                    state <= IDLE;
                end else begin
                    gap <= gap + 1'b1;
                end
                START: begin
                    state <= WAIT;
                    wcnt  <= '0;
                end
                // A result arriving on the last allowed cycle beats the timeout.
                WAIT: if (wait_done) begin
                    state <= SEND;
                end else if (USE_DONE != 0 && wcnt == WAIT_W'(TIMEOUT - 1)) begin
                    err_timeout <= 1'b1;
                    state       <= IDLE;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                SEND: if (sent) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    act_frame_ser #(.N_BYTES(N_BYTES)) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (capture),
        .res_data (bus.res_data),
        .tx_ready (bus.tx_ready),
        .tx_data  (bus.tx_data),
        .tx_valid (tx_valid),
        .sent     (sent)
    );

    assign bus.tx_valid    = tx_valid;
    assign bus.tx_line_en  = tx_valid;
    assign bus.op_data     = op_data;
    assign bus.op_start    = op_start;
    assign bus.err_timeout = err_timeout;
    assign bus.busy        = state != IDLE;
    assign bus.err_overrun = bus.rx_valid && (state == START || state == WAIT || state == SEND);
endmodule

// File: doc/uart_act_channel.md
Name: uart_act_channel

Overview:
- Parametrised successor to the single-byte UART/activation channel.
- Assembles a multi-byte operand from a UART byte stream, hands it to an activation engine (cordic tanh or similar) over a start/done handshake or a fixed-latency wait, then serialises the multi-byte result back to the UART transmitter.
- Sits between basic_uart and the activation core in each MLP test channel.
- Adds a receive-gap timeout, a compute timeout and overrun flagging.

Parameters:
- N_BYTES, 2, bytes per operand/result frame (1..4); DATA_W = 8*N_BYTES.
- USE_DONE, 1, 1 = wait for res_done; 0 = wait FIXED_LAT cycles and ignore res_done.
- FIXED_LAT, 16, compute wait in cycles when USE_DONE=0 (1..255).
- TIMEOUT, 255, maximum WAIT cycles before abort when USE_DONE=1.
- RX_GAP, 1023, maximum idle cycles between bytes of one frame before the partial frame is discarded.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from UART.
- rx_valid  in  1  one-cycle strobe: rx_data valid.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts the byte in any cycle where tx_valid & tx_ready.
- op_data  out  DATA_W  assembled operand to activation core.
- op_start  out  1  one-cycle start pulse.
- res_data  in  DATA_W  result from activation core.
- res_done  in  1  one-cycle result-valid strobe.
- tx_line_en  out  1  high while the frame is being sent (drives line tri-state enable).
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on compute timeout.
- err_overrun  out  1  one-cycle pulse when rx_valid arrives outside IDLE/RECV.

Behaviour:
- Reset, asynchronous active-low: state = IDLE; all outputs 0; op_data = 0; byte index, gap counter and wait counter = 0.
- Byte order: little-endian; the first received byte is op_data[7:0]. The first transmitted byte is res[7:0].
- IDLE:
  - On rx_valid: store byte 0, idx = 1.
  - Go to START if N_BYTES = 1, otherwise go to RECV.
- RECV:
  - Each rx_valid stores the byte at idx and increments idx; the gap counter clears.
  - After byte N_BYTES-1 is stored, go to START.
  - The gap counter increments on cycles without rx_valid. On reaching RX_GAP, drop the frame (op_data unchanged from its last complete frame) and go to IDLE with no error pulse.
- START:
  - op_start = 1 for exactly one cycle, then go to WAIT; wait counter = 0.
  - op_start rises one cycle after the cycle in which the final byte is sampled.
- WAIT, USE_DONE=1:
  - res_done captures res_data into the result register and moves to SEND.
  - If the counter reaches TIMEOUT first, pulse err_timeout and go to IDLE; nothing is transmitted.
  - If res_done arrives in the same cycle the counter hits TIMEOUT, res_done wins.
- WAIT, USE_DONE=0: after FIXED_LAT cycles, capture res_data and go to SEND.
- SEND:
  - tx_line_en = 1 and tx_valid = 1; tx_data = result byte at idx.
  - On tx_valid & tx_ready, advance idx. After the last byte is accepted, go to IDLE the next cycle with tx_valid = 0.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
- rx_valid in START, WAIT or SEND: byte discarded, err_overrun pulses in the same cycle.
- res_done outside WAIT is ignored.
- op_data holds its value after START until the next frame completes.
- Reset asserted mid-frame or mid-send aborts immediately to IDLE; tx_valid drops asynchronously.

Optional Feature:
- Macro: UART_ACT_CHANNEL_CHECKSUM_EN.
- Enabled:
  - Each rx frame carries one trailing byte equal to the XOR of the N_BYTES data bytes. Mismatch: frame dropped, go to IDLE, err_cksum (extra 1-bit output port) pulses.
  - Each tx frame appends the XOR of its result bytes as a final byte.
- Disabled: no checksum byte is expected or sent; the err_cksum port does not exist.

Decomposition:
- Package uart_act_pkg holds:
  - the state enum (IDLE, RECV, START, WAIT, SEND);
  - a byte-index width function clog2(N_BYTES+1);
  - the counter width constants.
- One natural sub-module: act_frame_ser, the result register plus byte-indexed tx serialiser with the valid/ready hold logic, and the checksum append when enabled.

Test Plan:
- N_BYTES=2, USE_DONE=1: rx 0x34 then 0x12; core returns 0xBEEF after 5 cycles -> op_data=0x1234, one op_start pulse, tx bytes 0xEF then 0xBE, busy low afterwards.
- USE_DONE=0, FIXED_LAT=16: single frame -> res_data sampled exactly 16 cycles after the WAIT entry cycle; res_done pulses are ignored.
- USE_DONE=1, TIMEOUT=8, no res_done -> err_timeout pulses at cycle 8 of WAIT, no tx_valid, back to IDLE; the next frame processes normally.
- tx_ready held low for 10 cycles mid-send -> tx_data/tx_valid stable throughout; rx_valid injected during SEND -> err_overrun pulse, tx frame unaffected.
- RX_GAP=20: send one byte, then idle 25 cycles -> frame discarded, no op_start; a following full frame works.
- CHECKSUM_EN: rx 0x34,0x12,0x26 accepted, tx appends 0x51 for result 0xBEEF; rx 0x34,0x12,0x00 -> err_cksum pulse, no op_start.
